// File: rtl/btb_update_ctrl.sv
// BTB update controller: BHT prediction in IF, branch resolution in EX,
// registered BTB write commands, fetch redirect and performance counters.
module btb_update_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_btb_hit,
  input  logic [31:0] if_btb_target,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_is_br,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        if_pred_taken,
  output logic [1:0]  web,
  output logic [31:0] waddr,
  output logic [31:0] wr_data,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam logic [1:0] WEB_NONE = 2'b00;
  localparam logic [1:0] WEB_UPD  = 2'b01;
  localparam logic [1:0] WEB_ADD  = 2'b10;
  localparam logic [1:0] WEB_INV  = 2'b11;
  localparam logic [1:0] CNT_RST  = 2'b01;

  logic [1:0]  r_bht [64];

  logic        r_id_v;
  logic [31:0] r_id_pc;
  logic        r_id_hit;
  logic [31:0] r_id_tgt;
  logic        r_id_pred;

  logic        r_ex_v;
  logic [31:0] r_ex_pc;
  logic        r_ex_hit;
  logic [31:0] r_ex_tgt;
  logic        r_ex_pred;

  logic [1:0]  r_web;
  logic [31:0] r_waddr;
  logic [31:0] r_wr_data;
  logic        r_mispredict;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_br_cnt;
  logic [31:0] r_mispred_cnt;

  logic        w_pred;
  logic [5:0]  w_ex_idx;
  logic        w_resolve;
  logic [1:0]  w_bht_cur;
  logic [1:0]  w_bht_new;
  logic        w_tgt_diff;
  logic        w_mis;
  logic [1:0]  w_web;
  logic [31:0] w_redirect;

  // Reads the registered table, so a same-cycle update is not visible here.
  assign w_pred    = if_btb_hit & r_bht[if_pc[7:2]][1];
  assign w_ex_idx  = r_ex_pc[7:2];
  assign w_resolve = r_ex_v & ex_is_br & ~stall;
  assign w_bht_cur = r_bht[w_ex_idx];
  assign w_tgt_diff = ex_target != r_ex_tgt;
  assign w_mis = (r_ex_pred ^ ex_taken)
               | (r_ex_pred & ex_taken & w_tgt_diff);
  assign w_redirect = ex_taken ? ex_target : r_ex_pc + 32'd4;

  always_comb begin
    w_bht_new = w_bht_cur;
    if (ex_taken && w_bht_cur != 2'b11)
      w_bht_new = w_bht_cur + 2'd1;
    else if (!ex_taken && w_bht_cur != 2'b00)
      w_bht_new = w_bht_cur - 2'd1;
  end

  always_comb begin
    w_web = WEB_NONE;
    unique case (1'b1)
      ex_taken & ~r_ex_hit:              w_web = WEB_ADD;
      ex_taken & r_ex_hit & w_tgt_diff:  w_web = WEB_UPD;
      ~ex_taken & r_ex_hit
        & (w_bht_new == 2'b00):          w_web = WEB_INV;
      default:                           w_web = WEB_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++)
        r_bht[i] <= CNT_RST;
    end else if (w_resolve) begin
      r_bht[w_ex_idx] <= w_bht_new;
    end
  end

  // Flush drops both stages but still latches the IF payload into ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_v    <= 1'b0;
      r_id_pc   <= '0;
      r_id_hit  <= 1'b0;
      r_id_tgt  <= '0;
      r_id_pred <= 1'b0;
      r_ex_v    <= 1'b0;
      r_ex_pc   <= '0;
      r_ex_hit  <= 1'b0;
      r_ex_tgt  <= '0;
      r_ex_pred <= 1'b0;
    end else if (flush) begin
      r_id_v    <= 1'b0;
      r_ex_v    <= 1'b0;
      r_id_pc   <= if_pc;
      r_id_hit  <= if_btb_hit;
      r_id_tgt  <= if_btb_target;
      r_id_pred <= w_pred;
    end else if (!stall) begin
      r_ex_v    <= r_id_v;
      r_ex_pc   <= r_id_pc;
      r_ex_hit  <= r_id_hit;
      r_ex_tgt  <= r_id_tgt;
      r_ex_pred <= r_id_pred;
      r_id_v    <= 1'b1;
      r_id_pc   <= if_pc;
      r_id_hit  <= if_btb_hit;
      r_id_tgt  <= if_btb_target;
      r_id_pred <= w_pred;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_web         <= WEB_NONE;
      r_waddr       <= '0;
      r_wr_data     <= '0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_web         <= WEB_NONE;
      r_waddr       <= '0;
      r_wr_data     <= '0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      if (w_resolve) begin
        r_br_cnt <= r_br_cnt + 32'd1;
        r_web    <= w_web;
        if (w_web != WEB_NONE)
          r_waddr <= r_ex_pc;
        if (w_web == WEB_ADD || w_web == WEB_UPD)
          r_wr_data <= ex_target;
        if (w_mis) begin
          r_mispredict  <= 1'b1;
          r_redirect_pc <= w_redirect;
          r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
      end
    end
  end

  assign if_pred_taken = w_pred;
  assign web           = r_web;
  assign waddr         = r_waddr;
  assign wr_data       = r_wr_data;
  assign mispredict    = r_mispredict;
  assign redirect_pc   = r_redirect_pc;
  assign br_cnt        = r_br_cnt;
  assign mispred_cnt   = r_mispred_cnt;

endmodule
